lcd_text_ctrl: RTL and testbench

Parametrised HD44780-class character LCD controller for 8-bit parallel, write-only panels. It runs the power-on init sequence, then continuously refreshes one or two display lines from an internal character buffer that user logic writes through a simple write port. It sits between application logic and the LCD pins and replaces fixed-text LCD drivers.

---
 rtl/lcd_pkg.sv | 37 +++
 rtl/lcd_text_ctrl_if.sv | 13 +
 rtl/lcd_step_timer.sv | 38 +++
 rtl/lcd_text_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_lcd_text_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared command codes, FSM state type and character constants for lcd_text_ctrl.
// The ST_SHIFT state is compiled in only when LCD_SHIFT_EN is defined.
package lcd_pkg;

  localparam logic [7:0] FUNC_8BIT_2L = 8'h38;
  localparam logic [7:0] FUNC_8BIT_1L = 8'h30;
  localparam logic [7:0] CLEAR        = 8'h01;
  localparam logic [7:0] DISP_ON      = 8'h0C;
  localparam logic [7:0] ENTRY_INC    = 8'h06;
  localparam logic [7:0] DDRAM_L0     = 8'h80;
  localparam logic [7:0] DDRAM_L1     = 8'hC0;
  localparam logic [7:0] SHIFT_L      = 8'h18;
  localparam logic [7:0] SHIFT_R      = 8'h1C;

  localparam logic [7:0] SPACE_CHAR = 8'h20;
  localparam int         WR_ADDR_W  = 6;

  typedef enum logic [3:0] {
    ST_PWR_WAIT,
    ST_FUNC_SET,
    ST_CLEAR,
    ST_DISP_ON,
    ST_ENTRY,
    ST_SET_ADDR,
    ST_WRITE_CHAR,
    ST_GAP
`ifdef LCD_SHIFT_EN
    , ST_SHIFT
`endif
  } lcd_state_e;

  // Wait states keep the panel idle; every other state issues one enable pulse.
  function automatic logic state_strobes(input lcd_state_e s);
    return !(s inside {ST_PWR_WAIT, ST_GAP});
  endfunction

endpackage

// File: rtl/lcd_text_ctrl_if.sv
// Character-buffer write port of lcd_text_ctrl: user logic is the master,
// the controller is the slave.
interface lcd_text_ctrl_if;
  import lcd_pkg::*;

  logic                 wr_en;
  logic [WR_ADDR_W-1:0] wr_addr;
  logic [7:0]           wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);

endinterface

// File: rtl/lcd_step_timer.sv
// Free-running step timer: one step is STEP_CYCLES clocks; flags the first and
// last cycle of each step and the centred half-step window used for lcd_en.
module lcd_step_timer #(
  parameter int STEP_CYCLES = 270000
) (
  input  logic clk,
  input  logic reset,
  output logic step_tick,
  output logic step_start,
  output logic en_window
);

  localparam int            CW     = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0] LAST   = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] EN_ON  = CW'(STEP_CYCLES / 4);
  localparam logic [CW-1:0] EN_OFF = CW'(3 * STEP_CYCLES / 4);

  logic [CW-1:0] count;
  logic [CW-1:0] count_n;

  always_comb count_n = (count == LAST) ? '0 : count + CW'(1);

  // NOTE: registers are written with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      en_window <= 1'b0;
    end else begin
      count     <= count_n;
      en_window <= (count_n >= EN_ON) && (count_n < EN_OFF);
    end
  end

  assign step_tick  = (count == LAST);
  assign step_start = (count == '0);

endmodule

// File: rtl/lcd_text_ctrl.sv
// HD44780-class 8-bit write-only LCD controller: power-on init, then continuous
// refresh of 1-2 lines from a character buffer. LCD_SHIFT_EN adds periodic display shift.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int STEP_CYCLES = 270000,
  parameter int PWR_STEPS   = 20,
  parameter int NUM_LINES   = 2,
  parameter int COLS        = 16,
  parameter int GAP_STEPS   = 2
`ifdef LCD_SHIFT_EN
  , parameter int SHIFT_FRAMES = 4
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef LCD_SHIFT_EN
  input  logic                  shift_en,
  input  logic                  shift_dir,
`endif
  lcd_text_ctrl_if.slave        wr_bus,
  output logic                  init_done,
  output logic                  lcd_rs,
  output logic                  lcd_rw,
  output logic                  lcd_en,
  output logic [7:0]            lcd_data
);

  localparam int BUF_DEPTH = NUM_LINES * COLS;
  localparam int BUF_AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W     = 16;

  logic step_tick, step_start, en_window;

  lcd_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .step_tick  (step_tick),
    .step_start (step_start),
    .en_window  (en_window)
  );

  lcd_state_e        state, state_n;
  logic              line, line_n;
  logic [5:0]        col, col_n;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_n;
  logic              rs_n;
  logic [7:0]        data_n;
  logic              bus_active;
  logic [BUF_AW-1:0] rd_idx;
  logic [7:0]        char_buf [BUF_DEPTH];

  // NOTE: the buffer carries a reset because it must read as spaces after every
  // reset; that keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) char_buf[i] <= SPACE_CHAR;
    end else if (wr_bus.wr_en && (int'(wr_bus.wr_addr) < BUF_DEPTH)) begin
      char_buf[BUF_AW'(wr_bus.wr_addr)] <= wr_bus.wr_data;
    end
  end

`ifdef LCD_SHIFT_EN
  localparam int FCW = (SHIFT_FRAMES > 1) ? $clog2(SHIFT_FRAMES) : 1;
  logic [FCW-1:0] frame_cnt;
  logic           frame_end, shift_due;

  assign frame_end = (state == ST_GAP) && (wait_cnt == CNT_W'(GAP_STEPS - 1));
  assign shift_due = shift_en && (frame_cnt == FCW'(SHIFT_FRAMES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     frame_cnt <= '0;
    else if (!shift_en)             frame_cnt <= '0;
    else if (step_tick && frame_end) frame_cnt <= shift_due ? '0 : frame_cnt + FCW'(1);
  end
`endif

  // Next state is computed every cycle but only committed on a step tick, and
  // the bus value for the coming step is decoded from that next state.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statements can infer a latch.
    state_n    = state;
    line_n     = line;
    col_n      = col;
    wait_cnt_n = wait_cnt;
    rs_n       = 1'b0;
    data_n     = 8'h00;

    case (state)
      ST_PWR_WAIT: begin
        if (wait_cnt == CNT_W'(PWR_STEPS - 1)) begin
          state_n    = ST_FUNC_SET;
          wait_cnt_n = '0;
        end else begin
          wait_cnt_n = wait_cnt + CNT_W'(1);
        end
      end
      ST_FUNC_SET: state_n = ST_CLEAR;
      ST_CLEAR:    state_n = ST_DISP_ON;
      ST_DISP_ON:  state_n = ST_ENTRY;
      ST_ENTRY: begin
        state_n = ST_SET_ADDR;
        line_n  = 1'b0;
      end
      ST_SET_ADDR: begin
        state_n = ST_WRITE_CHAR;
        col_n   = '0;
      end
      ST_WRITE_CHAR: begin
        if (col == 6'(COLS - 1)) begin
          col_n = '0;
          if (line == 1'(NUM_LINES - 1)) begin
            state_n    = ST_GAP;
            wait_cnt_n = '0;
          end else begin
            state_n = ST_SET_ADDR;
            line_n  = 1'b1;
          end
        end else begin
          col_n = col + 6'd1;
        end
      end
      ST_GAP: begin
        if (wait_cnt == CNT_W'(GAP_STEPS - 1)) begin
          wait_cnt_n = '0;
          line_n     = 1'b0;
`ifdef LCD_SHIFT_EN
          state_n = shift_due ? ST_SHIFT : ST_SET_ADDR;
`else
          state_n = ST_SET_ADDR;
`endif
        end else begin
          wait_cnt_n = wait_cnt + CNT_W'(1);
        end
      end
`ifdef LCD_SHIFT_EN
      ST_SHIFT: begin
        state_n = ST_SET_ADDR;
        line_n  = 1'b0;
      end
`endif
      default: state_n = ST_PWR_WAIT;
    endcase

    rd_idx = BUF_AW'(int'(line_n) * COLS + int'(col_n));

    case (state_n)
      ST_FUNC_SET:   data_n = (NUM_LINES == 2) ? FUNC_8BIT_2L : FUNC_8BIT_1L;
      ST_CLEAR:      data_n = CLEAR;
      ST_DISP_ON:    data_n = DISP_ON;
      ST_ENTRY:      data_n = ENTRY_INC;
      ST_SET_ADDR:   data_n = line_n ? DDRAM_L1 : DDRAM_L0;
      ST_WRITE_CHAR: begin
        rs_n   = 1'b1;
        data_n = char_buf[rd_idx];
      end
`ifdef LCD_SHIFT_EN
      ST_SHIFT:      data_n = shift_dir ? SHIFT_R : SHIFT_L;
`endif
      default:       data_n = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_PWR_WAIT;
      line       <= 1'b0;
      col        <= '0;
      wait_cnt   <= '0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
      bus_active <= 1'b0;
      init_done  <= 1'b0;
    end else if (step_tick) begin
      state      <= state_n;
      line       <= line_n;
      col        <= col_n;
      wait_cnt   <= wait_cnt_n;
      lcd_rs     <= rs_n;
      lcd_data   <= data_n;
      bus_active <= state_strobes(state_n);
      if (state == ST_ENTRY) init_done <= 1'b1;
    end
  end

  // lcd_en gates two registers; bus_active only changes at a step boundary,
  // where the enable window is always closed, so the strobe cannot glitch.
  assign lcd_en = en_window & bus_active;
  assign lcd_rw = 1'b0;

  a_en_closed_at_boundary : assert property (
    @(posedge clk) disable iff (!reset) (step_tick || step_start) |-> !en_window
  );

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Directed bench for lcd_text_ctrl with STEP_CYCLES=8, PWR_STEPS=3, 2 lines x 4 cols.
// Step s after reset release spans cycles 8s..8s+7; outputs are sampled on the falling edge.
module tb_lcd_text_ctrl;
  import lcd_pkg::*;

  localparam int STEP = 8;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       init_done, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;
`ifdef LCD_SHIFT_EN
  logic       shift_en  = 1'b0;
  logic       shift_dir = 1'b0;
`endif

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  lcd_text_ctrl_if bus ();

  lcd_text_ctrl #(
    .STEP_CYCLES (STEP),
    .PWR_STEPS   (3),
    .NUM_LINES   (2),
    .COLS        (4),
    .GAP_STEPS   (2)
`ifdef LCD_SHIFT_EN
    , .SHIFT_FRAMES (2)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef LCD_SHIFT_EN
    .shift_en  (shift_en),
    .shift_dir (shift_dir),
`endif
    .wr_bus    (bus),
    .init_done (init_done),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .lcd_data  (lcd_data)
  );

  always #5 clk = ~clk;

  // Cycle index since the last reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic go_cycle(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic write_char(input logic [5:0] addr, input logic [7:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  // Expected bus per step of a frame with 'A' at index 5 only.
  logic [7:0] frame_data [12] = '{8'h80, 8'h20, 8'h20, 8'h20, 8'h20, 8'hC0,
                                  8'h20, 8'h41, 8'h20, 8'h20, 8'h00, 8'h00};
  logic       frame_rs   [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       frame_en   [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic en_seen;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_en",   32'(lcd_en),    32'h0);
    check("rst_rs",   32'(lcd_rs),    32'h0);
    check("rst_rw",   32'(lcd_rw),    32'h0);
    check("rst_data", 32'(lcd_data),  32'h00);
    check("rst_init", 32'(init_done), 32'h0);

    reset = 1'b1;   // released at a falling edge: cycle 0 begins

    // Writes before init: index 5 = 'A', index 8 is out of range
    write_char(6'd5, 8'h41);
    write_char(6'd8, 8'h5A);

    en_seen = 1'b0;
    for (int c = 2; c <= 25; c++) begin
      go_cycle(c);
      en_seen |= lcd_en;
    end
    check("pwr_wait_en_low", 32'(en_seen), 32'h0);

    go_cycle(26);
    check("first_en_rise", 32'(lcd_en),   32'h1);
    check("func_set_rs",   32'(lcd_rs),   32'h0);
    check("func_set_data", 32'(lcd_data), 32'h38);
    go_cycle(29);
    check("first_en_last_high", 32'(lcd_en), 32'h1);
    go_cycle(30);
    check("first_en_fall", 32'(lcd_en), 32'h0);

    go_cycle(4 * STEP + 3);
    check("clear_data", 32'(lcd_data), 32'h01);
    go_cycle(5 * STEP + 3);
    check("disp_on_data", 32'(lcd_data), 32'h0C);
    go_cycle(6 * STEP + 3);
    check("entry_data", 32'(lcd_data), 32'h06);
    check("init_low_in_entry", 32'(init_done), 32'h0);
    go_cycle(7 * STEP);
    check("init_done_rise", 32'(init_done), 32'h1);

    // Frame 0: steps 7..18
    for (int k = 0; k < 12; k++) begin
      go_cycle((7 + k) * STEP + 3);
      check($sformatf("f0_data_s%0d", k), 32'(lcd_data), 32'(frame_data[k]));
      check($sformatf("f0_rs_s%0d", k),   32'(lcd_rs),   32'(frame_rs[k]));
      check($sformatf("f0_en_s%0d", k),   32'(lcd_en),   32'(frame_en[k]));
    end

    // Gap must keep lcd_en low for every cycle of both steps
    en_seen = 1'b0;
    for (int c = 17 * STEP; c < 19 * STEP; c++) begin
      go_cycle(c);
      en_seen |= lcd_en;
    end
    check("gap_en_low", 32'(en_seen), 32'h0);
    go_cycle(19 * STEP + 3);
    check("f1_set_addr", 32'(lcd_data), 32'h80);

    // Overwrite index 0 while it is on the bus (step 20)
    go_cycle(20 * STEP + 3);
    write_char(6'd0, 8'h42);
    go_cycle(20 * STEP + 5);
    check("collision_old_value", 32'(lcd_data), 32'h20);
    go_cycle(32 * STEP + 3);
    check("collision_next_frame", 32'(lcd_data), 32'h42);
    go_cycle(33 * STEP + 3);
    check("neighbour_untouched", 32'(lcd_data), 32'h20);

    // Reset during WRITE_CHAR showing 'A'
    go_cycle(38 * STEP + 3);
    check("pre_reset_char", 32'(lcd_data), 32'h41);
    reset = 1'b0;
    #1;
    check("midrst_data", 32'(lcd_data),  32'h00);
    check("midrst_rs",   32'(lcd_rs),    32'h0);
    check("midrst_en",   32'(lcd_en),    32'h0);
    check("midrst_init", 32'(init_done), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    go_cycle(26);
    check("reinit_en",   32'(lcd_en),   32'h1);
    check("reinit_data", 32'(lcd_data), 32'h38);
    go_cycle(6 * STEP + 3);
    check("reinit_init_low", 32'(init_done), 32'h0);
    go_cycle(8 * STEP + 3);
    check("buf_cleared_idx0", 32'(lcd_data), 32'h20);
    go_cycle(14 * STEP + 3);
    check("buf_cleared_idx5", 32'(lcd_data), 32'h20);

`ifdef LCD_SHIFT_EN
    // Shift every 2nd frame: frames 0 and 1 complete, SHIFT at step 31
    shift_en  = 1'b1;
    shift_dir = 1'b0;
    go_cycle(31 * STEP + 3);
    check("shift_left_data", 32'(lcd_data), 32'h18);
    check("shift_left_rs",   32'(lcd_rs),   32'h0);
    check("shift_left_en",   32'(lcd_en),   32'h1);
    go_cycle(32 * STEP + 3);
    check("after_shift_addr", 32'(lcd_data), 32'h80);
    go_cycle(45 * STEP + 3);
    shift_en = 1'b0;
    go_cycle(56 * STEP + 3);
    check("no_shift_after_drop", 32'(lcd_data), 32'h80);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
